led_pulse_emitter: RTL

Converts an 8-bit count into a train of visible LED blinks, the output-direction counterpart to the button press counter that turns physical presses into a count. A client presents a count with a one-cycle start request. The block then blinks a PMOD LED exactly that many times with fixed on/off timing, closes with an idle gap, and signals completion. It is used to read out counter values on boards with few LEDs.

---
 rtl/led_pulse_emitter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/led_pulse_emitter.sv
// Blinks an LED COUNT times with fixed on/off timing, then holds dark for an idle gap
// and strobes DONE. Every output comes straight from a flop.
`timescale 1ns/1ps
module led_pulse_emitter #(
  parameter int ON_CYCLES  = 2400000,
  parameter int OFF_CYCLES = 2400000,
  parameter int GAP_CYCLES = 12000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COUNT,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] REMAINING,
  output logic       LED_ON,
  output logic       LED_N
);

  localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYC    = (MAX_ON_OFF > GAP_CYCLES) ? MAX_ON_OFF : GAP_CYCLES;
  // A one-cycle-only configuration still needs a one-bit timer.
  localparam int TMR_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             led_on_q, led_on_d;
  logic             led_n_q, led_n_d;
  logic             timer_zero;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    timer_zero  = (timer_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          remaining_d = COUNT;
          if (COUNT != 8'd0) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
          end else begin
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end
        end
      end
      ST_ON: begin
        if (timer_zero) begin
          // The pulse counts as delivered on its last lit cycle.
          remaining_d = remaining_q - 8'd1;
          if (remaining_q != 8'd1) begin
            state_d = ST_OFF;
            timer_d = OFF_LOAD;
          end else begin
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_OFF: begin
        if (timer_zero) begin
          state_d = ST_ON;
          timer_d = ON_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs are decoded from the next state so they land in flops alongside it.
    busy_d   = (state_d != ST_IDLE);
    led_on_d = (state_d == ST_ON);
    led_n_d  = ~led_on_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      remaining_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      led_on_q    <= 1'b0;
      led_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      led_on_q    <= led_on_d;
      led_n_q     <= led_n_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign REMAINING = remaining_q;
  assign LED_ON    = led_on_q;
  assign LED_N     = led_n_q;

endmodule
